// File: rtl/rand_arbiter.sv
// Random-word arbiter: hands words from one upstream PRNG to NumReq requesters.
// Each requester owns a one-word slot. A round-robin pointer picks among eligible
// requesters, and per-requester wait counters raise a sticky starvation flag.
module rand_arbiter #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned RandWidth   = 32,
    parameter int unsigned StarveLimit = 64
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        RandInValid,
    output logic                        RandInReady,
    input  logic [RandWidth-1:0]        RandIn,
    input  logic [NumReq-1:0]           ReqValid,
    output logic [NumReq-1:0]           OutValid,
    input  logic [NumReq-1:0]           OutReady,
    output logic [NumReq*RandWidth-1:0] OutData,
    output logic [NumReq-1:0]           Starved
);

    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = $clog2(StarveLimit + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

    logic [NumReq-1:0]    fullQ, fullD;
    logic [RandWidth-1:0] dataQ [NumReq];
    logic [PtrW-1:0]      ptrQ, ptrD;
    logic [CntW-1:0]      waitQ [NumReq];
    logic [CntW-1:0]      waitD [NumReq];
    logic [NumReq-1:0]    starvedQ, starvedD;

    logic [NumReq-1:0]    drain;
    logic [NumReq-1:0]    eligible;
    logic [NumReq-1:0]    load;
    logic [PtrW-1:0]      winner;
    logic                 anyEligible;
    logic                 grant;

    // Eligibility: requester wants a word and its slot is free or emptying this cycle.
    always_comb begin
        drain       = fullQ & OutReady;
        eligible    = ReqValid & (~fullQ | drain);
        anyEligible = |eligible;
        grant       = RandInValid && anyEligible;
    end

    // Reset gates ready so upstream never sees a handshake while state is held clear.
    assign RandInReady = RandInValid && anyEligible && !Reset;

    // Round-robin pick: scan offsets high to low so the smallest offset from ptrQ wins.
    always_comb begin
        int idx;
        winner = '0;
        idx    = 0;
        for (int off = int'(NumReq) - 1; off >= 0; off--) begin
            idx = int'(ptrQ) + off;
            if (idx >= int'(NumReq)) begin
                idx = idx - int'(NumReq);
            end
            if (eligible[idx]) begin
                winner = PtrW'(idx);
            end
        end
    end

    // Slot occupancy and pointer advance.
    always_comb begin
        load = '0;
        if (grant) begin
            load[winner] = 1'b1;
        end
        // A drained slot that is reloaded in the same cycle stays full.
        fullD = (fullQ & ~drain) | load;
        ptrD  = ptrQ;
        if (grant) begin
            if (int'(winner) == int'(NumReq) - 1) begin
                ptrD = '0;
            end else begin
                ptrD = winner + 1'b1;
            end
        end
    end

    // Wait counters saturate at the limit; the flag sets on the edge the limit is reached.
    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            if (load[i] || !ReqValid[i]) begin
                waitD[i] = '0;
            end else if (!fullQ[i] && (waitQ[i] != CntMax)) begin
                waitD[i] = waitQ[i] + 1'b1;
            end else begin
                waitD[i] = waitQ[i];
            end
            starvedD[i] = starvedQ[i] | (waitD[i] == CntMax);
        end
    end

    // State registers; asynchronous reset drops every held word at once.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fullQ    <= '0;
            ptrQ     <= '0;
            starvedQ <= '0;
            for (int i = 0; i < int'(NumReq); i++) begin
                dataQ[i] <= '0;
                waitQ[i] <= '0;
            end
        end else begin
            fullQ    <= fullD;
            ptrQ     <= ptrD;
            starvedQ <= starvedD;
            for (int i = 0; i < int'(NumReq); i++) begin
                waitQ[i] <= waitD[i];
                if (load[i]) begin
                    dataQ[i] <= RandIn;
                end
            end
        end
    end

    // Flatten slot registers onto the output bus.
    always_comb begin
        OutData = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            OutData[i*RandWidth +: RandWidth] = dataQ[i];
        end
    end

    assign OutValid = fullQ;
    assign Starved  = starvedQ;

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed bench for rand_arbiter with NumReq=4, RandWidth=32, StarveLimit=64.
module tb_rand_arbiter;

    logic        Clock;
    logic        Reset;
    logic        RandInValid;
    logic        RandInReady;
    logic [31:0] RandIn;
    logic [3:0]  ReqValid;
    logic [3:0]  OutValid;
    logic [3:0]  OutReady;
    logic [127:0] OutData;
    logic [3:0]  Starved;

    int total;
    int bad;

    rand_arbiter #(
        .NumReq      (4),
        .RandWidth   (32),
        .StarveLimit (64)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .RandInValid (RandInValid),
        .RandInReady (RandInReady),
        .RandIn      (RandIn),
        .ReqValid    (ReqValid),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .OutData     (OutData),
        .Starved     (Starved)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [31:0] slot(input int i);
        return OutData[i*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        Reset       = 1'b1;
        RandInValid = 1'b1;
        RandIn      = 32'd99;
        ReqValid    = 4'b1111;
        OutReady    = 4'b1111;

        // Reset state: everything clear, ready suppressed even with live requests.
        #1;
        chk("rst_ready", {31'd0, RandInReady}, 32'd0);
        chk("rst_valid", {28'd0, OutValid}, 32'd0);
        step();
        step();
        chk("rst_starved", {28'd0, Starved}, 32'd0);
        chk("rst_data0", slot(0), 32'd0);
        chk("rst_data3", slot(3), 32'd0);

        // Round robin over all requesters, words 1..5 -> 0,1,2,3,0.
        Reset  = 1'b0;
        RandIn = 32'd1;
        #1;
        chk("rr_ready", {31'd0, RandInReady}, 32'd1);
        step();
        chk("rr_v1", {28'd0, OutValid}, 32'b0001);
        chk("rr_d1", slot(0), 32'd1);
        RandIn = 32'd2;
        step();
        chk("rr_v2", {28'd0, OutValid}, 32'b0010);
        chk("rr_d2", slot(1), 32'd2);
        RandIn = 32'd3;
        step();
        chk("rr_v3", {28'd0, OutValid}, 32'b0100);
        chk("rr_d3", slot(2), 32'd3);
        RandIn = 32'd4;
        step();
        chk("rr_v4", {28'd0, OutValid}, 32'b1000);
        chk("rr_d4", slot(3), 32'd4);
        RandIn = 32'd5;
        step();
        chk("rr_v5", {28'd0, OutValid}, 32'b0001);
        chk("rr_d5", slot(0), 32'd5);
        RandInValid = 1'b0;
        step();
        chk("rr_drained", {28'd0, OutValid}, 32'd0);

        // Single requester with continuous drain gets one word per cycle.
        ReqValid    = 4'b0100;
        OutReady    = 4'b0100;
        RandInValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            RandIn = 32'd10 + k;
            #1;
            chk("solo_ready", {31'd0, RandInReady}, 32'd1);
            step();
            chk("solo_valid", {28'd0, OutValid}, 32'b0100);
            chk("solo_data", slot(2), 32'd10 + k);
        end
        RandInValid = 1'b0;
        ReqValid    = 4'b0000;
        step();
        chk("solo_end", {28'd0, OutValid}, 32'd0);

        // Blocked slot holds its first word; dropping ReqValid does not flush it.
        ReqValid    = 4'b0010;
        OutReady    = 4'b0000;
        RandInValid = 1'b1;
        RandIn      = 32'd20;
        #1;
        chk("blk_ready0", {31'd0, RandInReady}, 32'd1);
        step();
        chk("blk_valid", {28'd0, OutValid}, 32'b0010);
        RandIn = 32'd21;
        #1;
        chk("blk_ready1", {31'd0, RandInReady}, 32'd0);
        step();
        step();
        chk("blk_hold", slot(1), 32'd20);
        ReqValid = 4'b0000;
        step();
        chk("blk_noflush", {28'd0, OutValid}, 32'b0010);
        chk("blk_noflush_d", slot(1), 32'd20);
        RandInValid = 1'b0;
        OutReady    = 4'b0010;
        step();
        chk("blk_drain", {28'd0, OutValid}, 32'd0);
        chk("blk_stale", slot(1), 32'd20);
        OutReady = 4'b0000;

        // Starvation: flag rises exactly on the 64th waiting cycle.
        ReqValid = 4'b1000;
        for (int k = 0; k < 63; k++) begin
            step();
        end
        chk("starve_63", {28'd0, Starved}, 32'd0);
        step();
        chk("starve_64", {28'd0, Starved}, 32'b1000);
        RandInValid = 1'b1;
        RandIn      = 32'd30;
        OutReady    = 4'b1000;
        step();
        chk("starve_grant", {28'd0, OutValid}, 32'b1000);
        chk("starve_data", slot(3), 32'd30);
        chk("starve_sticky1", {28'd0, Starved}, 32'b1000);
        ReqValid    = 4'b0000;
        RandInValid = 1'b0;
        step();
        chk("starve_sticky2", {28'd0, Starved}, 32'b1000);
        OutReady = 4'b0000;

        // Fill slots 0 and 2, then pulse reset between edges.
        ReqValid    = 4'b0101;
        RandInValid = 1'b1;
        RandIn      = 32'd40;
        step();
        RandIn = 32'd41;
        step();
        chk("fill_valid", {28'd0, OutValid}, 32'b0101);
        chk("fill_d0", slot(0), 32'd40);
        chk("fill_d2", slot(2), 32'd41);
        ReqValid = 4'b1111;
        #1;
        chk("pre_rst_ready", {31'd0, RandInReady}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_valid", {28'd0, OutValid}, 32'd0);
        chk("arst_starved", {28'd0, Starved}, 32'd0);
        chk("arst_ready", {31'd0, RandInReady}, 32'd0);
        chk("arst_d0", slot(0), 32'd0);
        step();
        Reset    = 1'b0;
        OutReady = 4'b1111;
        RandIn   = 32'd50;
        step();
        chk("post_rst_v", {28'd0, OutValid}, 32'b0001);
        chk("post_rst_d", slot(0), 32'd50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
